// File: rtl/door_pkg.sv
// Shared constants for the door controller front end: button FSM encodings
// and the default synchroniser / debounce depths.
package door_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int SYNC_STAGES_DEF     = 2;

  typedef logic [1:0] btn_state_t;

  localparam btn_state_t BTN_IDLE  = 2'b00;
  localparam btn_state_t BTN_PULSE = 2'b01;
  localparam btn_state_t BTN_HELD  = 2'b10;

endpackage

// File: rtl/door_debouncer.sv
// One input channel: SYNC_STAGES-deep synchroniser followed by a counter
// debouncer that only accepts a level held for DEBOUNCE_CYCLES samples.
module door_debouncer
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic dout
);

  localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sample_s;
  logic                   stable_r;
  logic [CW-1:0]          cnt_r;

  assign sample_s = sync_r[SYNC_STAGES-1];
  assign dout     = stable_r;

  // Metastability chain for the asynchronous raw input.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Any agreeing sample restarts the count, so short glitches never toggle the level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stable_r <= 1'b0;
      cnt_r    <= '0;
    end else if (sample_s == stable_r) begin
      cnt_r    <= '0;
    end else if (cnt_r == CNT_LAST) begin
      stable_r <= ~stable_r;
      cnt_r    <= '0;
    end else begin
      cnt_r    <= cnt_r + CNT_ONE;
    end
  end

endmodule

// File: rtl/door_input_conditioner.sv
// Conditions the push-button and both limit switches for the door controller:
// one Activate pulse per debounced press, clean limit levels, sensor fault flag.
module door_input_conditioner
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic Btn_Raw,
  input  logic Up_Sw_Raw,
  input  logic Dn_Sw_Raw,
  output logic Activate,
  output logic Up_Max,
  output logic Dn_Max,
  output logic Sensor_Fault
);

  logic       db_btn_s;
  btn_state_t state_r;
  btn_state_t state_nxt_s;
  logic       act_nxt_s;

  door_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_btn_db (
    .CLK(CLK), .RST(RST), .din(Btn_Raw), .dout(db_btn_s)
  );

  door_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_up_db (
    .CLK(CLK), .RST(RST), .din(Up_Sw_Raw), .dout(Up_Max)
  );

  door_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_dn_db (
    .CLK(CLK), .RST(RST), .din(Dn_Sw_Raw), .dout(Dn_Max)
  );

  // Button FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= BTN_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // A new pulse needs a debounced release back to idle first.
  always_comb begin
    state_nxt_s = BTN_IDLE;
    case (state_r)
      BTN_IDLE: begin
        if (db_btn_s) state_nxt_s = BTN_PULSE;
        else          state_nxt_s = BTN_IDLE;
      end
      BTN_PULSE: state_nxt_s = BTN_HELD;
      BTN_HELD: begin
        if (db_btn_s) state_nxt_s = BTN_HELD;
        else          state_nxt_s = BTN_IDLE;
      end
      default: state_nxt_s = BTN_IDLE;
    endcase
  end

  // A press during a sensor fault is consumed without a pulse.
  always_comb begin
    act_nxt_s = 1'b0;
    case (state_r)
      BTN_PULSE: act_nxt_s = ~Sensor_Fault;
      default:   act_nxt_s = 1'b0;
    endcase
  end

  // Registered outputs toward the controller.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Activate     <= 1'b0;
      Sensor_Fault <= 1'b0;
    end else begin
      Activate     <= act_nxt_s;
      Sensor_Fault <= Up_Max & Dn_Max;
    end
  end

endmodule

// File: tb/tb_door_input_conditioner.sv
// Self-checking bench for door_input_conditioner: a level/pulse vector table
// plus hand-written timing sequences, with Activate pulses checked from a queue.
module tb_door_input_conditioner;

  typedef struct {
    logic btn;
    logic up;
    logic dn;
    int   hold;
    logic e_up;
    logic e_dn;
    logic e_flt;
    logic e_pulse;
  } vec_t;

  typedef struct {
    logic e_up;
    logic e_dn;
    logic e_flt;
  } lvl_t;

  logic CLK;
  logic RST;
  logic Btn_Raw;
  logic Up_Sw_Raw;
  logic Dn_Sw_Raw;
  logic Activate;
  logic Up_Max;
  logic Dn_Max;
  logic Sensor_Fault;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_pulses = 0;
  int   n_expected_pulses = 0;
  int   act_q[$];
  lvl_t lvl_q[$];
  vec_t vecs[10];

  door_input_conditioner dut (
    .CLK(CLK),
    .RST(RST),
    .Btn_Raw(Btn_Raw),
    .Up_Sw_Raw(Up_Sw_Raw),
    .Dn_Sw_Raw(Dn_Sw_Raw),
    .Activate(Activate),
    .Up_Max(Up_Max),
    .Dn_Max(Dn_Max),
    .Sensor_Fault(Sensor_Fault)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input logic b, input logic u, input logic d);
    Btn_Raw   = b;
    Up_Sw_Raw = u;
    Dn_Sw_Raw = d;
  endtask

  // raw rise sampled on the next edge; Activate is seen 8 edges later
  task automatic expect_pulse();
    act_q.push_back(cyc + 8);
    n_expected_pulses++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_activate"}, Activate, 0);
    chk({tag, "_up_max"}, Up_Max, 0);
    chk({tag, "_dn_max"}, Dn_Max, 0);
    chk({tag, "_fault"}, Sensor_Fault, 0);
  endtask

  // Pulse monitor: every Activate-high cycle must match a queued expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (Activate === 1'b1) begin
        n_pulses++;
        if (act_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL act_unexpected: Activate high at cycle %0d, no pulse expected", cyc);
        end else begin
          chk("act_cycle", cyc, act_q.pop_front());
        end
      end
    end
  end

  initial begin
    lvl_t e;

    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick(3);
    chk_all_zero("reset");
    RST = 1'b1;
    tick(2);

    //          btn   up    dn    hold e_up  e_dn  e_flt e_pulse
    vecs[0] = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 10, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 12, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 12, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].btn, vecs[i].up, vecs[i].dn);
      if (vecs[i].e_pulse) expect_pulse();
      lvl_q.push_back('{vecs[i].e_up, vecs[i].e_dn, vecs[i].e_flt});
      tick(vecs[i].hold);
      e = lvl_q.pop_front();
      chk($sformatf("vec%0d_up_max", i), Up_Max, e.e_up);
      chk($sformatf("vec%0d_dn_max", i), Dn_Max, e.e_dn);
      chk($sformatf("vec%0d_fault", i), Sensor_Fault, e.e_flt);
    end
    chk("table_pulses", n_pulses, n_expected_pulses);

    // Reset while the FSM sits in BTN_PULSE and Up_Max is already high.
    drive(1'b1, 1'b1, 1'b0);
    tick(7);
    chk("pre_reset_up_max", Up_Max, 1);
    #2 RST = 1'b0;
    #1 chk_all_zero("reset_mid");
    tick(2);
    RST = 1'b1;
    expect_pulse();
    tick(5);
    chk("rst_rel_up_max_5", Up_Max, 0);
    tick(1);
    chk("rst_rel_up_max_6", Up_Max, 1);
    tick(6);
    drive(1'b0, 1'b0, 1'b0);
    tick(12);
    chk("reset_pulses", n_pulses, n_expected_pulses);

    // Glitch of 3 cycles is rejected, 4 cycles is accepted.
    drive(1'b1, 1'b0, 1'b0);
    tick(3);
    drive(1'b0, 1'b0, 1'b0);
    tick(12);
    chk("glitch3_pulses", n_pulses, n_expected_pulses);
    drive(1'b1, 1'b0, 1'b0);
    expect_pulse();
    tick(4);
    drive(1'b0, 1'b0, 1'b0);
    tick(14);
    chk("glitch4_pulses", n_pulses, n_expected_pulses);

    // Long hold yields one pulse; a second press after release yields another.
    drive(1'b1, 1'b0, 1'b0);
    expect_pulse();
    tick(50);
    drive(1'b0, 1'b0, 1'b0);
    tick(12);
    drive(1'b1, 1'b0, 1'b0);
    expect_pulse();
    tick(20);
    drive(1'b0, 1'b0, 1'b0);
    tick(12);
    chk("hold_pulses", n_pulses, n_expected_pulses);

    // Down limit latency and bounce rejection.
    drive(1'b0, 1'b0, 1'b1);
    tick(5);
    chk("dn_rise_5", Dn_Max, 0);
    tick(1);
    chk("dn_rise_6", Dn_Max, 1);
    drive(1'b0, 1'b0, 1'b0);
    tick(10);
    chk("dn_fall", Dn_Max, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, (i % 2) == 0);
      tick(1);
      chk("bounce_dn_low", Dn_Max, 0);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("bounce_settle_low", Dn_Max, 0);
    end
    tick(1);
    chk("bounce_dn_high", Dn_Max, 1);
    drive(1'b0, 1'b0, 1'b0);
    tick(10);

    // Sensor fault set and clear latency.
    drive(1'b0, 1'b1, 1'b1);
    tick(6);
    chk("flt_up_max", Up_Max, 1);
    chk("flt_dn_max", Dn_Max, 1);
    chk("flt_not_yet", Sensor_Fault, 0);
    tick(1);
    chk("flt_set", Sensor_Fault, 1);
    drive(1'b0, 1'b0, 1'b1);
    tick(6);
    chk("flt_up_fell", Up_Max, 0);
    chk("flt_still", Sensor_Fault, 1);
    tick(1);
    chk("flt_clear", Sensor_Fault, 0);
    drive(1'b0, 1'b0, 1'b0);
    tick(10);

    // Back-to-back presses at the minimum 13-cycle period.
    for (int p = 0; p < 4; p++) begin
      drive(1'b1, 1'b0, 1'b0);
      expect_pulse();
      tick(7);
      drive(1'b0, 1'b0, 1'b0);
      tick(6);
    end
    tick(12);
    chk("b2b_pulses", n_pulses, n_expected_pulses);

    tick(5);
    chk("pulses_total", n_pulses, n_expected_pulses);
    chk("act_pending", act_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/door_input_conditioner.md
# door_input_conditioner

Front-end stage for the door controller. It synchronises and debounces the raw push-button and the two limit switches. It then drives the controller's Activate, Up_Max and Dn_Max inputs with clean, glitch-free levels. Activate is a single-cycle pulse per physical press, and a sensor-consistency fault flag is provided for supervision.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a level change; legal range ≥ 2.
- SYNC_STAGES, 2: synchroniser depth per raw input; legal range ≥ 2.
- CLK  input  1  system clock, all flops on rising edge.
- RST  input  1  asynchronous, active-low reset.
- Btn_Raw  input  1  raw user push-button; asynchronous; active high.
- Up_Sw_Raw  input  1  raw "door fully open" limit switch; asynchronous.
- Dn_Sw_Raw  input  1  raw "door fully closed" limit switch; asynchronous.
- Activate  output  1  one-cycle pulse per accepted button press; feeds the controller's Activate.
- Up_Max  output  1  debounced open-limit level.
- Dn_Max  output  1  debounced closed-limit level.
- Sensor_Fault  output  1  registered; high while both debounced limits are high.

## Operation
- Three identical channels: button, up switch, down switch. Each has a SYNC_STAGES-deep flop chain followed by a debouncer.
- Debouncer behaviour:
  - Holds a stable level and a counter of width $clog2(DEBOUNCE_CYCLES).
  - When the synchronised sample equals the stable level, the counter clears to 0.
  - When the sample differs, the counter increments.
  - On the cycle the sample differs and the counter equals DEBOUNCE_CYCLES-1, the stable level toggles and the counter clears.
  - Any single agreeing sample restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles never propagate.
- Up_Max and Dn_Max are the stable levels of their channels.
- Button FSM runs on the debounced button level (db_btn):
  - BTN_IDLE: if db_btn=1, go to BTN_PULSE.
  - BTN_PULSE: go to BTN_HELD unconditionally.
  - BTN_HELD: if db_btn=0, go to BTN_IDLE.
- Activate = (state == BTN_PULSE) && !Sensor_Fault, registered. A held button produces exactly one pulse, and a new pulse requires a debounced release first.
- Sensor_Fault is registered from (Up_Max && Dn_Max). A press during a fault still advances the FSM but emits no pulse; it is consumed.
- Reset values:
  - Activate=0, Up_Max=0, Dn_Max=0, Sensor_Fault=0.
  - All synchroniser flops 0, all counters 0, FSM in BTN_IDLE.
  - Limits read "neither" after reset, so the controller stays idle until the switches settle.
- Reset asserted mid-debounce or mid-pulse aborts immediately to the reset values. No pulse is emitted on reset release, even if the button is held; the press is first accepted as a 0→1 debounced transition after release.

## Timing
- Raw edge to synchronised sample: SYNC_STAGES cycles.
- Raw level change, held stable, to the debounced output change: SYNC_STAGES + DEBOUNCE_CYCLES cycles (6 with defaults).
- Debounced button rise to Activate high: 2 cycles (FSM update, then output register). Activate is high for exactly 1 cycle.
- Debounced Up_Max/Dn_Max rising together to Sensor_Fault high: 1 cycle. Sensor_Fault clears 1 cycle after either falls.
- Simultaneous events:
  - Fault and BTN_PULSE evaluated on the same edge: the registered Sensor_Fault value used is the pre-edge one; Activate is suppressed only if Sensor_Fault is already high.
  - The three channels are independent; simultaneous changes are each debounced separately.
- Minimum press-to-press period: 2·(SYNC_STAGES + DEBOUNCE_CYCLES) + 1 cycles.

## Structure
- Shared package door_pkg:
  - Button FSM state localparams BTN_IDLE=2'b00, BTN_PULSE=2'b01, BTN_HELD=2'b10.
  - Default DEBOUNCE_CYCLES and SYNC_STAGES constants.
- Sub-module door_debouncer (parameters DEBOUNCE_CYCLES, SYNC_STAGES; ports CLK, RST, din, dout), instantiated three times.
- Top level holds the button FSM, the Activate register and the Sensor_Fault register. An unreachable state code (2'b11) returns to BTN_IDLE with Activate=0.

## Test plan
All scenarios use the defaults, DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
- Reset: assert RST=0 mid-operation with Btn_Raw=1 and Up_Sw_Raw=1 → all outputs 0 immediately; after release, Up_Max=1 six cycles later, and Activate pulses once only after the button debounces high.
- Glitch rejection: Btn_Raw high for 3 cycles, then low → db_btn never rises and Activate stays 0. Btn_Raw high for 4 cycles → db_btn rises.
- Single pulse: Btn_Raw held high for 50 cycles → exactly one Activate pulse, 8 cycles after the raw rise. Release, then a second press → a second single pulse.
- Limit tracking: Dn_Sw_Raw 0→1 → Dn_Max rises 6 cycles later. Bounce of 1,0,1,0,1 at 1 cycle each, then stable 1 → Dn_Max rises 6 cycles after the last edge, with no intermediate toggles.
- Fault: Up_Sw_Raw=Dn_Sw_Raw=1 stable → Sensor_Fault rises 1 cycle after both debounced; a button press during the fault → Activate stays 0. Drop Up_Sw_Raw → Sensor_Fault clears 7 cycles after the raw fall.
- Back-to-back presses at the minimum 13-cycle period → one Activate pulse per press, with none missed.
